shared_io_arbiter: RTL and testbench
====================================

# shared_io_arbiter

Arbitrates ownership of a single shared bidirectional (inout) net among N on-chip requesters, so that exactly one driver, or none, is enabled at any time. It sits between the instances that share a common `IO` pin and the top-level inout port. Its job is to replace the direct multi-driver `assign` fan-in with a sequenced, contention-free scheme. It issues round-robin grants, bounds how long one requester may hold the net, and inserts turnaround cycles between owners.

## Interface
Parameters:
- `N`, default 3: number of requesters (2..16).
- `W`, default 1: width of the shared net.
- `MAX_HOLD`, default 4: maximum consecutive owned cycles while another requester waits (≥1).
- `TURN_CYC`, default 1: number of idle (undriven) cycles between owners (≥1).

Ports:
- `CLK` input 1: clock. Single clock domain; all logic is rising-edge.
- `ASYNCRESETN` input 1: asynchronous, active-low reset.
- `req` input N: `req[i]` high means requester i wants to drive the net.
- `wdata` input N*W: requester i's drive value is in `wdata[i*W +: W]`.
- `gnt` output N: one-hot-or-zero grant, registered.
- `gnt_id` output clog2(N): index of the current owner; 0 when there is no grant.
- `io_oe` output 1: tristate enable, equal to `|gnt`.
- `IO` inout W: shared net. It carries `wdata[gnt_id]` when `io_oe` is high, otherwise high-Z.
- `rdata` output W: `IO` sampled each cycle (1-cycle registered copy).
- `busy` output 1: high in states OWN and TURN.

## Operation
- FSM states: IDLE, OWN, TURN.
- IDLE:
  - If any `req` bit is high, select a winner round-robin starting at `ptr`.
  - Register `gnt` one-hot for the winner, set `ptr` to winner+1 (mod N), and go to OWN.
  - Otherwise stay in IDLE.
- OWN:
  - `hold_cnt` increments each cycle, saturating at `MAX_HOLD`.
  - If the owner's `req` drops, clear `gnt` and go to TURN.
  - If the owner's `req` stays high, `hold_cnt` reaches `MAX_HOLD`, and any other `req` bit is high, clear `gnt` (forced preemption) and go to TURN.
  - If the owner is alone, it holds the net indefinitely; the counter saturates and does not wrap.
- TURN:
  - `gnt` is 0 and `IO` is high-Z for exactly `TURN_CYC` cycles, counted by `turn_cnt`.
  - At the end, if any `req` is high, grant round-robin from `ptr` directly (next state OWN); else go to IDLE.
  - A preempted owner still requesting is eligible again, but only after the others in round-robin order.
- Round-robin search: the first set `req` bit at index `ptr, ptr+1, …, N-1, 0, …`.
- `hold_cnt` resets to 0 on every new grant.
- `gnt` is never multi-hot.
- `io_oe` is never high in TURN or IDLE.
- `IO` drive value is a combinational mux of `wdata` by `gnt_id`, gated by `io_oe`.
- `rdata` captures `IO` every cycle regardless of state.
- Changes to `req` bits of non-owners while in OWN have no effect until the arbitration point.

## Timing
- Reset values: `gnt`=0, `gnt_id`=0, `io_oe`=0, `IO`=Z, `rdata`=0, `busy`=0, `ptr`=0, `hold_cnt`=0, `turn_cnt`=0, state=IDLE.
- Reset assertion takes effect immediately and asynchronously, including mid-OWN. The net is released without waiting for a clock edge.
- Reset is released synchronously to `CLK` by the system.
- Grant latency from IDLE: `req` high before edge t gives `gnt` high after edge t, so `IO` is driven in cycle t+1.
- Release latency: owner `req` low before edge t gives `gnt` low after edge t. The net is then idle for `TURN_CYC` cycles; the next owner is granted at edge t+`TURN_CYC`.
- Preemption: the owner holds for exactly `MAX_HOLD` cycles, then TURN.
- Worst-case wait for a requester: (N-1)*(`MAX_HOLD`+`TURN_CYC`) + 1 cycles from assertion to grant.
- `rdata` lags `IO` by one cycle.

## Test plan
All scenarios use N=3, W=1, `MAX_HOLD`=4, `TURN_CYC`=1.
1. Reset: `ASYNCRESETN`=0 with `req`=3'b111 → `gnt`=0, `io_oe`=0, `IO`=Z, `busy`=0. Release reset with `req`=3'b010 → after 1 edge, `gnt`=3'b010, `gnt_id`=1, `IO`=`wdata[1]`.
2. Single requester: `req[0]` held high for 10 cycles → `gnt[0]` stays high for all cycles with no preemption. Drop `req[0]` → 1 cycle with `gnt`=0 and `IO`=Z, then IDLE and `busy`=0.
3. Round-robin with preemption: `req`=3'b111 held high → grant sequence 0,1,2,0. Each grant lasts 4 cycles, separated by 1 idle cycle; `io_oe` is never high during TURN.
4. Simultaneous events: owner 0 drops `req` in the same cycle that `req[2]` rises while `ptr`=1 → TURN for 1 cycle, then `gnt`=3'b100.
5. Mid-operation reset: assert `ASYNCRESETN` low between clock edges during OWN with requester 1 → `io_oe` falls before the next edge. After release with `req`=3'b011 → requester 0 is granted, because `ptr` was reset to 0.
6. Data path: owner 2 drives `wdata[2]`=1 → `IO`=1, and `rdata`=1 one cycle later. In TURN, with an external pull on `IO` of 0 → `rdata`=0.

Source files
------------

// File: rtl/shared_io_arbiter.sv
// Round-robin owner arbiter for one shared tristate net: bounded hold time per
// owner and guaranteed undriven turnaround cycles between owners.
module shared_io_arbiter #(
  parameter int unsigned N        = 3,
  parameter int unsigned W        = 1,
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned TURN_CYC = 1
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       wdata,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 io_oe,
  inout  wire  [W-1:0]         IO,
  output logic [W-1:0]         rdata,
  output logic                 busy
);

  localparam int unsigned IDW = $clog2(N);
  localparam int unsigned IW  = IDW + 1;
  localparam int unsigned HW  = $clog2(MAX_HOLD + 1);
  localparam int unsigned TW  = $clog2(TURN_CYC + 1);

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  hold_q, hold_d, hold_inc;
  logic [TW-1:0]  turn_q, turn_d;
  logic [N-1:0]   gnt_d;
  logic [IDW-1:0] gnt_id_d;
  logic           io_oe_d, busy_d;

  logic           win_found;
  logic [IDW-1:0] win_id, win_next;
  logic [IW-1:0]  idx;
  logic           owner_req, others_req;
  logic [W-1:0]   drive_val;

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IW'(ptr_q) + IW'(k);
      if (idx >= IW'(N)) idx = idx - IW'(N);
      if (!win_found && req[idx[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = idx[IDW-1:0];
      end
    end
    win_next = (win_id == IDW'(N - 1)) ? '0 : win_id + IDW'(1);
  end

  assign owner_req  = |(req & gnt);
  assign others_req = |(req & ~gnt);
  assign hold_inc   = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + HW'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    turn_d   = turn_q;
    gnt_d    = gnt;
    gnt_id_d = gnt_id;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d    = N'(1) << win_id;
          gnt_id_d = win_id;
          ptr_d    = win_next;
          hold_d   = '0;
          state_d  = OWN;
        end
      end
      OWN: begin
        hold_d = hold_inc;
        if (!owner_req || (hold_inc == HW'(MAX_HOLD) && others_req)) begin
          gnt_d    = '0;
          gnt_id_d = '0;
          turn_d   = '0;
          state_d  = TURN;
        end
      end
      TURN: begin
        if (turn_q == TW'(TURN_CYC - 1)) begin
          if (win_found) begin
            gnt_d    = N'(1) << win_id;
            gnt_id_d = win_id;
            ptr_d    = win_next;
            hold_d   = '0;
            state_d  = OWN;
          end else begin
            state_d  = IDLE;
          end
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end
      default: begin
        gnt_d    = '0;
        gnt_id_d = '0;
        state_d  = IDLE;
      end
    endcase
    io_oe_d = |gnt_d;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      io_oe   <= 1'b0;
      busy    <= 1'b0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      gnt     <= gnt_d;
      gnt_id  <= gnt_id_d;
      io_oe   <= io_oe_d;
      busy    <= busy_d;
      rdata   <= IO;
    end
  end

  // Owner's drive value, released to high-Z whenever nobody holds a grant.
  always_comb begin
    drive_val = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_id == IDW'(i)) drive_val = wdata[i*W +: W];
    end
  end

  assign IO = io_oe ? drive_val : {W{1'bz}};

endmodule

// File: tb/tb_shared_io_arbiter.sv
// Vector/scoreboard bench for shared_io_arbiter (N=3, W=1, MAX_HOLD=4, TURN_CYC=1).
module tb_shared_io_arbiter;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic [2:0] wdata = 3'b000;
  logic       pull_val = 1'b1;
  logic [2:0] gnt;
  logic [1:0] gnt_id;
  logic       io_oe, busy;
  logic [0:0] rdata;
  wire  [0:0] io_net;

  // External pull on the net, only active while the arbiter releases it.
  assign io_net = io_oe ? 1'bz : pull_val;

  always #5 CLK = ~CLK;

  shared_io_arbiter #(.N(3), .W(1), .MAX_HOLD(4), .TURN_CYC(1)) dut (
    .CLK(CLK), .ASYNCRESETN(rst_n), .req(req), .wdata(wdata),
    .gnt(gnt), .gnt_id(gnt_id), .io_oe(io_oe), .IO(io_net),
    .rdata(rdata), .busy(busy)
  );

  typedef struct {
    logic       rst_n;
    logic [2:0] req;
    logic [2:0] wdata;
    logic       pull;
    logic [2:0] exp_gnt;
    logic       exp_busy;
  } vec_t;

  typedef struct {
    logic [2:0] gnt;
    logic [1:0] id;
    logic       oe;
    logic       busy;
    logic       io;
    logic       rdata;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vnum  = 0;
  logic       prev_oe = 1'b0;
  logic [1:0] prev_id = 2'd0;

  function automatic logic [1:0] id_of(input logic [2:0] g);
    id_of = 2'd0;
    for (int i = 0; i < 3; i++) if (g[i]) id_of = 2'(i);
  endfunction

  function automatic void addv(input logic r, input logic [2:0] rq, input logic [2:0] wd,
                               input logic p, input logic [2:0] g, input logic b);
    vec_t v;
    v.rst_n = r; v.req = rq; v.wdata = wd; v.pull = p; v.exp_gnt = g; v.exp_busy = b;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one vector mid-cycle, queue its expectation, compare just after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge CLK);
    rst_n = v.rst_n; req = v.req; wdata = v.wdata; pull_val = v.pull;
    e.gnt   = v.exp_gnt;
    e.id    = id_of(v.exp_gnt);
    e.oe    = |v.exp_gnt;
    e.busy  = v.exp_busy;
    e.io    = e.oe ? v.wdata[e.id] : v.pull;
    e.rdata = v.rst_n ? (prev_oe ? v.wdata[prev_id] : v.pull) : 1'b0;
    prev_oe = e.oe;
    prev_id = e.id;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk($sformatf("v%0d.gnt", vnum),    8'(gnt),    8'(e.gnt));
    chk($sformatf("v%0d.gnt_id", vnum), 8'(gnt_id), 8'(e.id));
    chk($sformatf("v%0d.io_oe", vnum),  8'(io_oe),  8'(e.oe));
    chk($sformatf("v%0d.busy", vnum),   8'(busy),   8'(e.busy));
    chk($sformatf("v%0d.io", vnum),     8'(io_net), 8'(e.io));
    chk($sformatf("v%0d.rdata", vnum),  8'(rdata),  8'(e.rdata));
    vnum++;
  endtask

  task automatic run_vecs();
    while (vecs.size() > 0) apply(vecs.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with everyone requesting, then release with only requester 1.
    addv(0, 3'b111, 3'b101, 1, 3'b000, 0);
    addv(0, 3'b111, 3'b101, 1, 3'b000, 0);
    addv(1, 3'b010, 3'b101, 1, 3'b010, 1);
    addv(1, 3'b000, 3'b101, 1, 3'b000, 1);
    addv(1, 3'b000, 3'b101, 1, 3'b000, 0);
    // Lone requester 0 holds well past MAX_HOLD, then releases.
    for (int i = 0; i < 10; i++) addv(1, 3'b001, 3'b010, 1, 3'b001, 1);
    addv(1, 3'b000, 3'b010, 1, 3'b000, 1);
    addv(1, 3'b000, 3'b010, 1, 3'b000, 0);
    // Owner 0 drops as req[2] rises with ptr=1.
    addv(1, 3'b001, 3'b010, 1, 3'b001, 1);
    addv(1, 3'b001, 3'b010, 1, 3'b001, 1);
    addv(1, 3'b100, 3'b010, 1, 3'b000, 1);
    addv(1, 3'b100, 3'b010, 1, 3'b100, 1);
    addv(1, 3'b000, 3'b010, 1, 3'b000, 1);
    addv(1, 3'b000, 3'b010, 1, 3'b000, 0);
    // All requesting: 0,1,2,0, four cycles each with one idle cycle between.
    for (int k = 0; k < 4; k++) begin
      logic [2:0] g;
      g = 3'b001 << ((k == 3) ? 0 : k);
      for (int c = 0; c < 4; c++) addv(1, 3'b111, 3'b010, 1, g, 1);
      addv(1, 3'b111, 3'b010, 1, 3'b000, 1);
    end
    addv(1, 3'b000, 3'b010, 1, 3'b000, 0);
    // Owner 2 drives 1; pull-down shows through once released.
    addv(1, 3'b100, 3'b100, 0, 3'b100, 1);
    addv(1, 3'b100, 3'b100, 0, 3'b100, 1);
    addv(1, 3'b000, 3'b100, 0, 3'b000, 1);
    addv(1, 3'b000, 3'b100, 0, 3'b000, 0);
    // Owner 1 active, ahead of the mid-cycle reset.
    addv(1, 3'b010, 3'b101, 1, 3'b010, 1);
    addv(1, 3'b010, 3'b101, 1, 3'b010, 1);
    run_vecs();

    // Asynchronous reset between edges must release the net immediately.
    @(negedge CLK);
    rst_n = 1'b0;
    #1;
    chk("async_rst.io_oe", 8'(io_oe), 8'd0);
    chk("async_rst.gnt",   8'(gnt),   8'd0);
    chk("async_rst.busy",  8'(busy),  8'd0);
    chk("async_rst.io",    8'(io_net), 8'd1);

    addv(0, 3'b011, 3'b101, 1, 3'b000, 0);
    addv(1, 3'b011, 3'b101, 1, 3'b001, 1);
    addv(1, 3'b000, 3'b101, 1, 3'b000, 1);
    addv(1, 3'b000, 3'b101, 1, 3'b000, 0);
    // ptr=1 before reset: only a cleared pointer grants 0 afterwards.
    addv(1, 3'b001, 3'b101, 1, 3'b001, 1);
    addv(0, 3'b011, 3'b101, 1, 3'b000, 0);
    addv(1, 3'b011, 3'b101, 1, 3'b001, 1);
    addv(1, 3'b000, 3'b101, 1, 3'b000, 1);
    addv(1, 3'b000, 3'b101, 1, 3'b000, 0);
    run_vecs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
